// File: rtl/ofmap_pkg.sv
// Shared types and constants for the ofmap writer slice.
package ofmap_pkg;

    localparam int LANES  = 8;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 13;
    localparam int LANE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/ofmap_line_buf.sv
// Eight-lane word buffer: indexed write, synchronous clear, all lanes visible in parallel.
module ofmap_line_buf
    import ofmap_pkg::*;
(
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [LANE_W-1:0] i_idx,
    input  word_t             i_data,
    output word_t             o_lanes [0:LANES-1]
);

    word_t r_lanes [0:LANES-1];

    always_ff @(posedge CLK) begin
        if (!RSTN || i_clr) begin
            for (int i = 0; i < LANES; i++) begin
                r_lanes[i] <= '0;
            end
        end else if (i_we) begin
            r_lanes[i_idx] <= i_data;
        end
    end

    assign o_lanes = r_lanes;

endmodule

// File: rtl/ofmap_writer.sv
// Packs 32-bit ofmap words into 8-word groups and issues one wide SRAM write per group.
// Optional build macro OFMAP_RELU_EN: negative words are stored as zero.
module ofmap_writer
    import ofmap_pkg::*;
#(
    parameter int SIZE = 4096
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  word_t             in_data,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output word_t             sram_di [0:LANES-1],
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] SIZE_W = CNT_W'(SIZE);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_rem;
    logic [LANE_W-1:0]  r_grp_cnt;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [ADDR_W-1:0]  r_sram_addr;
    word_t              r_sram_di [0:LANES-1];
    word_t              w_lanes   [0:LANES-1];
    word_t              w_word;
    logic               w_accept;
    logic               w_grp_end;
    logic [CNT_W-1:0]   w_addr_sum;
    logic               w_unused_base;

    assign w_unused_base = ^base_addr[2:0];
    assign w_accept      = in_valid && in_ready;
    assign w_grp_end     = (r_grp_cnt == LANE_W'(LANES - 1)) || (r_rem == CNT_W'(1));
    assign w_addr_sum    = {1'b0, r_wr_addr} + CNT_W'(LANES);

`ifdef OFMAP_RELU_EN
    assign w_word = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign w_word = in_data;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (num_words == '0) ? DONE : FILL;
            FILL:    if (w_accept && w_grp_end) w_next = WRITE;
            WRITE:   w_next = (r_rem == '0) ? DONE : FILL;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == FILL);
        sram_we  = (r_state == WRITE);
        busy     = (r_state != IDLE);
        done     = (r_state == DONE);
    end

    // The outgoing group is captured on the same edge that accepts its last word, so the
    // write-cycle data merges the incoming word with lanes already sitting in the buffer.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_rem       <= '0;
            r_grp_cnt   <= '0;
            r_wr_addr   <= '0;
            r_sram_addr <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_sram_di[i] <= '0;
            end
        end else begin
            if (r_state == IDLE && start) begin
                r_rem     <= num_words;
                r_wr_addr <= {base_addr[ADDR_W-1:3], 3'b000};
                r_grp_cnt <= '0;
            end
            if (w_accept) begin
                r_rem     <= r_rem - CNT_W'(1);
                r_grp_cnt <= r_grp_cnt + LANE_W'(1);
                if (w_grp_end) begin
                    r_sram_addr <= r_wr_addr;
                    for (int i = 0; i < LANES; i++) begin
                        r_sram_di[i] <= (LANE_W'(i) == r_grp_cnt) ? w_word : w_lanes[i];
                    end
                end
            end
            if (r_state == WRITE) begin
                r_grp_cnt <= '0;
                r_wr_addr <= (w_addr_sum >= SIZE_W) ? ADDR_W'(w_addr_sum - SIZE_W)
                                                    : ADDR_W'(w_addr_sum);
            end
        end
    end

    ofmap_line_buf u_line_buf (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .i_clr   (r_state == WRITE),
        .i_we    (w_accept),
        .i_idx   (r_grp_cnt),
        .i_data  (w_word),
        .o_lanes (w_lanes)
    );

    assign sram_addr = r_sram_addr;
    assign sram_di   = r_sram_di;

endmodule

// File: tb/tb_ofmap_writer.sv
// Self-checking bench for ofmap_writer: job-level write model plus per-cycle SRAM-port monitor.
// Honours OFMAP_RELU_EN the same way as the design build.
module tb_ofmap_writer;

    localparam int SIZE = 4096;

    typedef struct packed {
        logic [11:0]      addr;
        logic [7:0][31:0] di;
    } wr_t;

    logic        CLK;
    logic        RSTN;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] num_words;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        sram_we;
    logic [11:0] sram_addr;
    logic [31:0] sram_di [0:7];
    logic        busy;
    logic        done;

    int               nCompared;
    int               nMismatched;
    wr_t              expQ[$];
    logic [31:0]      jobWords [0:4095];
    logic [11:0]      lastAddr;
    logic [7:0][31:0] lastDi;
    logic             monOn;
    logic             rstSampled;

    ofmap_writer #(.SIZE(SIZE)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_di   (sram_di),
        .busy      (busy),
        .done      (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) rstSampled = !RSTN;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelWord(input logic [31:0] w);
`ifdef OFMAP_RELU_EN
        return w[31] ? 32'h0 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [255:0] packDi();
        logic [7:0][31:0] v;
        for (int i = 0; i < 8; i++) v[i] = sram_di[i];
        return v;
    endfunction

    // Every cycle: writes must match the model queue in order; idle cycles must hold the last write.
    always @(negedge CLK) begin
        if (monOn) begin
            if (rstSampled) begin
                lastAddr = '0;
                lastDi   = '0;
            end
            if (sram_we) begin
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL unexpected_write: got addr %0h expected no write", sram_addr);
                end else begin
                    wr_t e;
                    e = expQ.pop_front();
                    checkOutput("wr_addr", 256'(sram_addr), 256'(e.addr));
                    checkOutput("wr_di", packDi(), e.di);
                end
                lastAddr = sram_addr;
                lastDi   = packDi();
            end else begin
                checkOutput("hold_addr", 256'(sram_addr), 256'(lastAddr));
                checkOutput("hold_di", packDi(), lastDi);
            end
        end
    end

    task automatic recoverReset();
        RSTN     = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        expQ.delete();
    endtask

    // Builds the expected writes for a job, runs it, and checks handshake/done timing.
    task automatic applyStimulus(input logic [11:0] base, input int num, input int validPct);
        int aligned;
        int groups;
        int idx;
        int cycles;
        int budget;
        wr_t w;

        aligned = int'(base) & ~7;
        groups  = (num + 7) / 8;
        for (int g = 0; g < groups; g++) begin
            w.addr = 12'((aligned + 8 * g) % SIZE);
            for (int i = 0; i < 8; i++) begin
                w.di[i] = (8 * g + i < num) ? modelWord(jobWords[8 * g + i]) : 32'h0;
            end
            expQ.push_back(w);
        end

        @(negedge CLK);
        start     = 1'b1;
        base_addr = base;
        num_words = 13'(num);
        @(negedge CLK);
        start     = 1'b0;
        checkOutput("busy_after_start", 256'(busy), 256'(1));
        if (num == 0) begin
            checkOutput("done_num0", 256'(done), 256'(1));
            checkOutput("ready_num0", 256'(in_ready), 256'(0));
            @(negedge CLK);
            checkOutput("idle_num0", 256'(busy), 256'(0));
            checkOutput("writes_left", 256'(expQ.size()), 256'(0));
            return;
        end
        checkOutput("ready_after_start", 256'(in_ready), 256'(1));

        idx    = 0;
        cycles = 0;
        budget = num * 20 + 50;
        while (idx < num && cycles < budget) begin
            in_valid = ($urandom_range(99) < validPct);
            in_data  = jobWords[idx];
            if (in_valid && in_ready) idx++;
            @(negedge CLK);
            cycles++;
        end
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        if (idx < num) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL feed_timeout: got %0d words accepted expected %0d", idx, num);
            recoverReset();
            return;
        end
        if (validPct >= 100) begin
            checkOutput("feed_cycles", 256'(cycles), 256'(num + (num - 1) / 8));
        end
        checkOutput("we_after_last", 256'(sram_we), 256'(1));
        checkOutput("ready_in_write", 256'(in_ready), 256'(0));
        @(negedge CLK);
        checkOutput("done_pulse", 256'(done), 256'(1));
        checkOutput("ready_in_done", 256'(in_ready), 256'(0));
        @(negedge CLK);
        checkOutput("done_cleared", 256'(done), 256'(0));
        checkOutput("busy_cleared", 256'(busy), 256'(0));
        checkOutput("ready_in_idle", 256'(in_ready), 256'(0));
        in_valid = 1'b0;
        checkOutput("writes_left", 256'(expQ.size()), 256'(0));
    endtask

    initial begin
        int accepted;
        int guard;

        nCompared   = 0;
        nMismatched = 0;
        monOn       = 1'b0;
        lastAddr    = '0;
        lastDi      = '0;
        RSTN        = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        num_words   = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_ready", 256'(in_ready), 256'(0));
        checkOutput("rst_we", 256'(sram_we), 256'(0));
        checkOutput("rst_addr", 256'(sram_addr), 256'(0));
        checkOutput("rst_di", packDi(), 256'(0));
        checkOutput("rst_busy", 256'(busy), 256'(0));
        checkOutput("rst_done", 256'(done), 256'(0));
        RSTN  = 1'b1;
        monOn = 1'b1;

        for (int i = 0; i < 16; i++) jobWords[i] = 32'(i + 1);
        applyStimulus(12'h010, 8, 100);
        checkOutput("t1_addr", 256'(lastAddr), 256'(12'h010));
        checkOutput("t1_lane0", 256'(lastDi[0]), 256'(1));
        checkOutput("t1_lane7", 256'(lastDi[7]), 256'(8));

        applyStimulus(12'h013, 11, 100);
        checkOutput("t2_addr", 256'(lastAddr), 256'(12'h018));
        checkOutput("t2_lane2", 256'(lastDi[2]), 256'(11));
        checkOutput("t2_lane3", 256'(lastDi[3]), 256'(0));

        applyStimulus(12'h000, 16, 55);
        checkOutput("t3_addr", 256'(lastAddr), 256'(12'h008));
        checkOutput("t3_lane7", 256'(lastDi[7]), 256'(16));

        applyStimulus(12'hFF8, 16, 100);
        checkOutput("t4_addr", 256'(lastAddr), 256'(12'h000));

        jobWords[0] = 32'hFFFF_FFFF;
        jobWords[1] = 32'h0000_0005;
        jobWords[2] = 32'h8000_0000;
        jobWords[3] = 32'h7FFF_FFFF;
        applyStimulus(12'h100, 4, 100);
`ifdef OFMAP_RELU_EN
        checkOutput("t5_lane0", 256'(lastDi[0]), 256'(32'h0));
        checkOutput("t5_lane2", 256'(lastDi[2]), 256'(32'h0));
`else
        checkOutput("t5_lane0", 256'(lastDi[0]), 256'(32'hFFFF_FFFF));
        checkOutput("t5_lane2", 256'(lastDi[2]), 256'(32'h8000_0000));
`endif
        checkOutput("t5_lane1", 256'(lastDi[1]), 256'(5));
        checkOutput("t5_lane3", 256'(lastDi[3]), 256'(32'h7FFF_FFFF));
        checkOutput("t5_lane4", 256'(lastDi[4]), 256'(0));

        for (int j = 0; j < 6; j++) begin
            int n;
            n = int'($urandom_range(1, 40));
            for (int i = 0; i < n; i++) jobWords[i] = $urandom;
            applyStimulus(12'($urandom), n, 60);
        end

        // Abort a job with reset after five accepted words: nothing may be written.
        @(negedge CLK);
        start     = 1'b1;
        base_addr = 12'h040;
        num_words = 13'd8;
        @(negedge CLK);
        start    = 1'b0;
        accepted = 0;
        guard    = 0;
        while (accepted < 5 && guard < 50) begin
            in_valid = 1'b1;
            in_data  = 32'(accepted + 100);
            if (in_ready) accepted++;
            @(negedge CLK);
            guard++;
        end
        in_valid = 1'b0;
        RSTN     = 1'b0;
        @(negedge CLK);
        checkOutput("abort_busy", 256'(busy), 256'(0));
        checkOutput("abort_ready", 256'(in_ready), 256'(0));
        checkOutput("abort_we", 256'(sram_we), 256'(0));
        checkOutput("abort_done", 256'(done), 256'(0));
        RSTN = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            checkOutput("abort_no_done", 256'(done), 256'(0));
        end
        applyStimulus(12'h000, 0, 100);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ofmap_writer.md
# ofmap_writer

Packs a stream of 32-bit output-feature-map words from the compute array into 8-word groups and writes each group into the ofmap SRAM with one wide write. It sits directly upstream of the ofmap SRAM and drives its address, write-enable and 8-lane data inputs. The ofmap base address is 8-aligned and wraps modulo SIZE. Only the write side of the SRAM is driven here; the read port is owned by the readout path.

## Interface
- SIZE, 4096, ofmap SRAM depth in words; a multiple of 8, at most 4096
- CLK  in  1  clock
- RSTN  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches base_addr and num_words; ignored while busy
- base_addr  in  12  first word address; bits [2:0] ignored (forced 0)
- num_words  in  13  total words to write, 0..4096
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid && in_ready
- in_data  in  32  input word, two's complement
- sram_we  out  1  write strobe to the ofmap SRAM WE
- sram_addr  out  12  group base address to the SRAM ADDR
- sram_di  out  32 x 8 (unpacked [0:7])  group data; lane i lands at sram_addr+i
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: waits for start.
  - FILL: collects input words.
  - WRITE: issues one SRAM write.
  - DONE: emits done.
- IDLE -> FILL on start with num_words > 0.
- IDLE -> DONE on start with num_words = 0.
- FILL: in_ready = 1. Each accepted word is stored in lane `grp_cnt`, then grp_cnt increments.
- FILL -> WRITE when the 8th lane is accepted, or when the final word of the job is accepted.
- WRITE:
  - sram_we = 1; sram_addr = wr_addr; sram_di = the buffer.
  - Unfilled lanes of a partial final group are driven 0.
  - wr_addr advances by 8, wrapping: if wr_addr+8 >= SIZE it becomes wr_addr+8-SIZE.
  - Lane buffer and grp_cnt clear.
  - WRITE -> DONE if words remaining is 0, else WRITE -> FILL.
- DONE: done = 1 for one cycle, then -> IDLE.
- Counters:
  - rem: 13-bit, loaded with num_words, decremented per accepted word.
  - grp_cnt: 3-bit.
  - wr_addr: 12-bit.
- in_ready is 0 in IDLE, WRITE and DONE.
- in_data is sampled only on a handshake; extra words offered after the job completes are not accepted.
- start arriving in FILL, WRITE or DONE is ignored.

## Timing
- Reset values: in_ready 0, sram_we 0, sram_addr 0, all sram_di lanes 0, busy 0, done 0. Lane buffer, counters and state are cleared, state = IDLE.
- Reset asserted mid-job aborts it with no SRAM write and no done pulse.
- start at cycle t: busy = 1 and in_ready = 1 at t+1.
- Group-completing word accepted at cycle t: sram_we = 1 at t+1 for exactly one cycle, with registered addr/data.
- done = 1 at t+2 after the final word; busy drops at t+3.
- Throughput: 8 words per 9 cycles (one bubble per group in WRITE).
- num_words = 0: start at t gives done at t+1, with no write.
- sram_we is never asserted outside WRITE. sram_addr/sram_di hold their last values when sram_we = 0.

## Configuration
- OFMAP_RELU_EN defined: each accepted word with bit 31 set is stored as 0 (ReLU applied before the buffer). Non-negative words pass unchanged.
- OFMAP_RELU_EN undefined: words are stored bit-exact.
- Timing is identical in both builds.

## Structure
- Package ofmap_pkg:
  - State enum (IDLE, FILL, WRITE, DONE).
  - Constants LANES = 8, ADDR_W = 12, DATA_W = 32, CNT_W = 13.
- Sub-module ofmap_line_buf: 8 x 32 lane buffer with indexed write, synchronous clear and parallel output. The top level holds the FSM, counters and address wrap.

## Test plan
- base=0x010, num=8, data 1..8 back-to-back -> single write at 0x010 with DI[0..7]=1..8; done 2 cycles after the last handshake; in_ready low in the write cycle.
- base=0x013, num=11, data 1..11 -> writes at 0x010 (1..8) and 0x018 (9,10,11,0,0,0,0,0); exactly two sram_we pulses.
- in_valid randomly deasserted, base=0, num=16, data 1..16 -> identical writes at 0x000 and 0x008; no word lost or duplicated.
- SIZE=4096, base=0xFF8, num=16 -> writes at 0xFF8 then 0x000.
- Data 0xFFFFFFFF, 5, 0x80000000, 0x7FFFFFFF (num=4):
  - With OFMAP_RELU_EN: lanes 0, 5, 0, 0x7FFFFFFF, then zeros.
  - Without: values unchanged.
- Reset held low for 1 cycle after 5 words accepted (num=8) -> no sram_we, busy 0 and in_ready 0 the cycle after. Then start with num=0 -> done 1 cycle later, no write.
